// File: rtl/rx78_kbd_pkg.sv
// Shared types, PS/2 set-2 prefix constants and the RX-78 key matrix map.
// The matrix map is consumed by rx78_ps2_parser; see rx78_keyboard for the RX78_KBD_ALLROWS_EN option.
package rx78_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam int         KBD_ROWS   = 9;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } kbd_key_t;

  typedef struct packed {
    logic       vld;
    logic       make;
    logic [3:0] row;
    logic [2:0] col;
  } kbd_evt_t;

  // {ext, code} -> matrix position; anything not listed is unmapped.
  function automatic kbd_key_t kbd_keymap(input logic ext, input logic [7:0] code);
    kbd_key_t k;
    k = '0;
    case ({ext, code})
      9'h01C:  k = {1'b1, 4'd2, 3'd1};  // A
      9'h05A:  k = {1'b1, 4'd1, 3'd0};  // Enter
      9'h029:  k = {1'b1, 4'd9, 3'd0};  // Space
      9'h175:  k = {1'b1, 4'd8, 3'd2};  // Up
      default: k = '0;
    endcase
    return k;
  endfunction

  // Keyboard acks / self-test results that can show up between scan codes.
  function automatic logic kbd_is_ack(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/rx78_ps2_parser.sv
// PS/2 set-2 sequence parser: turns E0/F0/E1-prefixed byte streams into one-cycle
// make/break events carrying the mapped matrix row/column.
module rx78_ps2_parser
  import rx78_kbd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output kbd_evt_t   evt_o
);

  kbd_state_e  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [15:0] tmo_q, tmo_d;
  kbd_key_t    key;
  logic        ext;

  assign ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign key = kbd_keymap(ext, data_i);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    evt_o   = '0;
    if (valid_i) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (data_i == PS2_EXT)        state_d = ST_EXT;
          else if (data_i == PS2_BRK)   state_d = ST_BRK;
          else if (data_i == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (!kbd_is_ack(data_i)) begin
            evt_o = {key.valid, 1'b1, key.row, key.col};
          end
        end
        ST_EXT: begin
          if (data_i == PS2_BRK) state_d = ST_EXT_BRK;
          else begin
            evt_o   = {key.valid, 1'b1, key.row, key.col};
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          evt_o   = {key.valid, 1'b0, key.row, key.col};
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is dropped so the next byte starts a fresh sequence.
      if (tmo_q == TIMEOUT - 16'd1) state_d = ST_IDLE;
      else                          tmo_d   = tmo_q + 16'd1;
    end
    if (state_d == ST_IDLE) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: rtl/rx78_keyboard.sv
// RX-78 keyboard front end: PS/2 parser, 9x8 key matrix and the port F4 strobe/read interface.
// Optional RX78_KBD_ALLROWS_EN: row 4'hF reads the OR of every row.
module rx78_keyboard
  import rx78_kbd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter int          ROWS    = KBD_ROWS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       io_sel,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       key_any
);

  kbd_evt_t              evt;
  logic [ROWS-1:0][7:0]  mat_q, mat_d;
  logic [3:0]            row_q, row_d;
  logic [7:0]            dout_q, dout_d;
  logic                  kany_q;
  logic [7:0]            all_cols;
  logic [7:0]            rd_val;

  rx78_ps2_parser #(.TIMEOUT(TIMEOUT)) u_parser (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (ps2_data),
    .valid_i (ps2_valid),
    .evt_o   (evt)
  );

  always_comb begin
    mat_d    = mat_q;
    all_cols = '0;
    rd_val   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (evt.vld && evt.row == 4'(r + 1)) mat_d[r][evt.col] = evt.make;
      all_cols = all_cols | mat_q[r];
      if (row_q == 4'(r + 1)) rd_val = mat_q[r];
    end
`ifdef RX78_KBD_ALLROWS_EN
    if (row_q == 4'hF) rd_val = all_cols;
`endif
  end

  // Reads sample mat_q, so a read coinciding with a PS/2 byte returns the pre-update row.
  always_comb begin
    row_d  = row_q;
    dout_d = dout_q;
    if (io_sel && io_wr)  row_d  = io_din[3:0];
    if (io_sel && !io_wr) dout_d = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat_q  <= '0;
      row_q  <= '0;
      dout_q <= '0;
      kany_q <= 1'b0;
    end else begin
      mat_q  <= mat_d;
      row_q  <= row_d;
      dout_q <= dout_d;
      kany_q <= |all_cols;
    end
  end

  assign io_dout = dout_q;
  assign key_any = kany_q;

endmodule
